// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: upstream immediate/mode with valid/ready,
// and downstream extended operand with valid/ready.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Handshaked immediate-extension stage: sign/zero/upper/branch(x4) extension, 1-cycle latency.
// Optional 1-entry skid register (registered in_ready) enabled by defining IMM_EXT_SKID_EN.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  imm_extend_pipe_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] outData_q, outData_d;
  logic [1:0]       outMode_q, outMode_d;

  logic [OUT_W-1:0] signExt;
  logic [OUT_W-1:0] zeroExt;
  logic [OUT_W-1:0] upperExt;
  logic [OUT_W-1:0] extData;
  logic             outValid;
  logic             inReady;
  logic             inFire;
  logic             outFire;
  logic             skidFull;

  // Branch mode reuses the sign extension; the two bits shifted out are sign copies.
  assign signExt  = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
  assign zeroExt  = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
  assign upperExt = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};

  always_comb begin
    extData = signExt;
    case (bus.in_mode)
      2'b00:   extData = signExt;
      2'b01:   extData = zeroExt;
      2'b10:   extData = upperExt;
      2'b11:   extData = signExt << 2;
      default: extData = signExt;
    endcase
  end

  assign outValid = (state_q == FULL);
  assign inFire   = bus.in_valid && inReady;
  assign outFire  = outValid && bus.out_ready;

`ifdef IMM_EXT_SKID_EN
  logic             skidFull_q, skidFull_d;
  logic [OUT_W-1:0] skidData_q, skidData_d;
  logic [1:0]       skidMode_q, skidMode_d;
  logic             inReady_q;

  assign skidFull = skidFull_q;
  assign inReady  = inReady_q;
`else
  assign skidFull = 1'b0;
  assign inReady  = !outValid || bus.out_ready;
`endif

  always_comb begin
    state_d   = state_q;
    outData_d = outData_q;
    outMode_d = outMode_q;
`ifdef IMM_EXT_SKID_EN
    skidFull_d = skidFull_q;
    skidData_d = skidData_q;
    skidMode_d = skidMode_q;
`endif
    case (state_q)
      EMPTY: begin
        if (inFire) begin
          state_d   = FULL;
          outData_d = extData;
          outMode_d = bus.in_mode;
        end
      end
      FULL: begin
        if (outFire && skidFull) begin
`ifdef IMM_EXT_SKID_EN
          outData_d  = skidData_q;
          outMode_d  = skidMode_q;
          skidFull_d = 1'b0;
`endif
        end else if (outFire && inFire) begin
          outData_d = extData;
          outMode_d = bus.in_mode;
        end else if (outFire) begin
          state_d = EMPTY;
        end else if (inFire) begin
          // Main register is stalled; park the new result behind it.
`ifdef IMM_EXT_SKID_EN
          skidFull_d = 1'b1;
          skidData_d = extData;
          skidMode_d = bus.in_mode;
`endif
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      outData_q <= '0;
      outMode_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      outData_q <= outData_d;
      outMode_q <= outMode_d;
    end
  end

`ifdef IMM_EXT_SKID_EN
  // in_ready tracks the skid occupancy one cycle late so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      skidFull_q <= 1'b0;
      skidData_q <= '0;
      skidMode_q <= 2'b00;
      inReady_q  <= 1'b1;
    end else begin
      skidFull_q <= skidFull_d;
      skidData_q <= skidData_d;
      skidMode_q <= skidMode_d;
      inReady_q  <= !skidFull_d;
    end
  end
`endif

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = outData_q;
  assign bus.out_mode  = outMode_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: a 16->32 instance and a 12->32 instance,
// table-driven extension vectors plus streaming, backpressure and mid-operation reset sequences.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus16 ();
  imm_extend_pipe_if #(.IN_W(12), .OUT_W(32)) bus12 ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(32)) dut12 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus12)
  );

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec16_t;

  typedef struct {
    logic [11:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec12_t;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs on the chosen bus at the falling edge, idles the other, then settles.
  task automatic applyStimulus(input bit useNarrow, input logic valid, input logic [15:0] imm,
                               input logic [1:0] mode, input logic outReady);
    @(negedge clk);
    if (useNarrow) begin
      bus12.in_valid  = valid;
      bus12.in_imm    = imm[11:0];
      bus12.in_mode   = mode;
      bus12.out_ready = outReady;
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
    end else begin
      bus16.in_valid  = valid;
      bus16.in_imm    = imm;
      bus16.in_mode   = mode;
      bus16.out_ready = outReady;
      bus12.in_valid  = 1'b0;
      bus12.out_ready = 1'b1;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec16_t      v16 [9];
    vec12_t      v12 [5];
    int          expRdy [10];
    int          expVal [10];
    logic [31:0] expDat [10];
    int          nextVal;
    int          outCount;

    v16[0] = '{16'hFFF8, 2'b00, 32'hFFFFFFF8};
    v16[1] = '{16'hFFF8, 2'b01, 32'h0000FFF8};
    v16[2] = '{16'h8000, 2'b00, 32'hFFFF8000};
    v16[3] = '{16'h8000, 2'b01, 32'h00008000};
    v16[4] = '{16'h1234, 2'b10, 32'h12340000};
    v16[5] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
    v16[6] = '{16'h0007, 2'b11, 32'h0000001C};
    v16[7] = '{16'h7FFF, 2'b00, 32'h00007FFF};
    v16[8] = '{16'h8001, 2'b11, 32'hFFFE0004};

    v12[0] = '{12'h800, 2'b00, 32'hFFFFF800};
    v12[1] = '{12'hABC, 2'b10, 32'hABC00000};
    v12[2] = '{12'hFFF, 2'b11, 32'hFFFFFFFC};
    v12[3] = '{12'hABC, 2'b01, 32'h00000ABC};
    v12[4] = '{12'h7FF, 2'b11, 32'h00001FFC};

`ifdef IMM_EXT_SKID_EN
    expRdy = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
`else
    expRdy = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
`endif
    expVal = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    expDat = '{32'h0, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h0};

    reset           = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_imm    = '0;
    bus16.in_mode   = 2'b00;
    bus16.out_ready = 1'b0;
    bus12.in_valid  = 1'b0;
    bus12.in_imm    = '0;
    bus12.in_mode   = 2'b00;
    bus12.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_valid16", 32'(bus16.out_valid), 32'd0);
    checkOutput("rst_data16",  bus16.out_data,       32'h0);
    checkOutput("rst_mode16",  32'(bus16.out_mode),  32'd0);
    checkOutput("rst_ready16", 32'(bus16.in_ready),  32'd1);
    checkOutput("rst_valid12", 32'(bus12.out_valid), 32'd0);
    checkOutput("rst_ready12", 32'(bus12.in_ready),  32'd1);

    // Extension table, streamed back to back; each result is checked one cycle after its accept.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, v16[i].imm, v16[i].mode, 1'b1);
      checkOutput($sformatf("tab_ready[%0d]", i), 32'(bus16.in_ready), 32'd1);
      if (i > 0) begin
        checkOutput($sformatf("tab_valid[%0d]", i-1), 32'(bus16.out_valid), 32'd1);
        checkOutput($sformatf("tab_data[%0d]",  i-1), bus16.out_data,       v16[i-1].exp);
        checkOutput($sformatf("tab_mode[%0d]",  i-1), 32'(bus16.out_mode),  32'(v16[i-1].mode));
      end
    end
    applyStimulus(1'b0, 1'b0, 16'hDEAD, 2'b11, 1'b1);
    checkOutput("tab_valid[8]", 32'(bus16.out_valid), 32'd1);
    checkOutput("tab_data[8]",  bus16.out_data,       v16[8].exp);
    checkOutput("tab_mode[8]",  32'(bus16.out_mode),  32'(v16[8].mode));
    applyStimulus(1'b0, 1'b0, 16'hBEEF, 2'b10, 1'b1);
    checkOutput("tab_drain_valid", 32'(bus16.out_valid), 32'd0);

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 16'(i), 2'b00, 1'b1);
      checkOutput($sformatf("str_ready[%0d]", i), 32'(bus16.in_ready), 32'd1);
      if (i > 1) begin
        checkOutput($sformatf("str_valid[%0d]", i-1), 32'(bus16.out_valid), 32'd1);
        checkOutput($sformatf("str_data[%0d]",  i-1), bus16.out_data,       32'(i-1));
      end
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
    checkOutput("str_valid[8]", 32'(bus16.out_valid), 32'd1);
    checkOutput("str_data[8]",  bus16.out_data,       32'd8);
    applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
    checkOutput("str_drain_valid", 32'(bus16.out_valid), 32'd0);

    // Backpressure: values 1..4 offered while out_ready is low on cycles 2-5.
    nextVal  = 1;
    outCount = 0;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b0, (nextVal <= 4), 16'(nextVal), 2'b00, !(c >= 2 && c <= 5));
      checkOutput($sformatf("bp_ready[%0d]", c), 32'(bus16.in_ready),  32'(expRdy[c-1]));
      checkOutput($sformatf("bp_valid[%0d]", c), 32'(bus16.out_valid), 32'(expVal[c-1]));
      if (expVal[c-1] != 0)
        checkOutput($sformatf("bp_data[%0d]", c), bus16.out_data, expDat[c-1]);
      if (bus16.in_valid && bus16.in_ready)
        nextVal++;
      if (bus16.out_valid && bus16.out_ready)
        outCount++;
    end
    checkOutput("bp_out_count", 32'(outCount), 32'd4);
    checkOutput("bp_in_count",  32'(nextVal),  32'd5);

    // Reset while stalled and (with the skid build) the skid entry occupied.
    applyStimulus(1'b0, 1'b1, 16'h0011, 2'b11, 1'b0);
    checkOutput("mr_ready0", 32'(bus16.in_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h0022, 2'b11, 1'b0);
    checkOutput("mr_valid_pre", 32'(bus16.out_valid), 32'd1);
    checkOutput("mr_data_pre",  bus16.out_data,       32'h00000044);
    checkOutput("mr_mode_pre",  32'(bus16.out_mode),  32'd3);
    @(negedge clk);
    reset           = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mr_valid", 32'(bus16.out_valid), 32'd0);
    checkOutput("mr_data",  bus16.out_data,       32'h0);
    checkOutput("mr_mode",  32'(bus16.out_mode),  32'd0);
    checkOutput("mr_ready", 32'(bus16.in_ready),  32'd1);
    applyStimulus(1'b0, 1'b1, 16'h0005, 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
    checkOutput("mr_post_valid", 32'(bus16.out_valid), 32'd1);
    checkOutput("mr_post_data",  bus16.out_data,       32'h00000005);
    checkOutput("mr_post_mode",  32'(bus16.out_mode),  32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
    checkOutput("mr_alone_valid", 32'(bus16.out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
    checkOutput("mr_alone_valid2", 32'(bus16.out_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, {4'h0, v12[i].imm}, v12[i].mode, 1'b1);
      checkOutput($sformatf("w12_ready[%0d]", i), 32'(bus12.in_ready), 32'd1);
      if (i > 0) begin
        checkOutput($sformatf("w12_valid[%0d]", i-1), 32'(bus12.out_valid), 32'd1);
        checkOutput($sformatf("w12_data[%0d]",  i-1), bus12.out_data,       v12[i-1].exp);
        checkOutput($sformatf("w12_mode[%0d]",  i-1), 32'(bus12.out_mode),  32'(v12[i-1].mode));
      end
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1);
    checkOutput("w12_valid[4]", 32'(bus12.out_valid), 32'd1);
    checkOutput("w12_data[4]",  bus12.out_data,       v12[4].exp);
    applyStimulus(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1);
    checkOutput("w12_drain_valid", 32'(bus12.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, handshaked immediate-extension stage. It replaces the fixed 16→32 registered sign/zero extender in the CPU decode path.
- Takes an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit operand.
- Modes: sign-extend, zero-extend, upper-immediate placement, or sign-extend with ×4 (branch offset).
- Sits between the instruction decoder and the ALU operand mux, with valid/ready flow control on both sides.

Parameters:
- IN_W, 16: immediate input width. Must be ≥2.
- OUT_W, 32: extended output width. Must be ≥ IN_W+2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an immediate.
- in_ready  output  1  stage can accept this cycle.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch (sign, shl 2).
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  OUT_W  extended result.
- out_mode  output  2  mode that produced out_data.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on port reset, sampled at the rising edge. No asynchronous paths.
- Transfers:
  - Input transfer when in_valid && in_ready at a rising edge.
  - Output transfer when out_valid && out_ready at a rising edge.
- Arithmetic, computed from in_imm/in_mode at the accepting edge:
  - 00: {(OUT_W-IN_W){in_imm[IN_W-1]}, in_imm}.
  - 01: {(OUT_W-IN_W){1'b0}, in_imm}.
  - 10: {in_imm, (OUT_W-IN_W){1'b0}}. The immediate occupies the top IN_W bits.
  - 11: {(OUT_W-IN_W-2){in_imm[IN_W-1]}, in_imm, 2'b00}. Bits shifted out above OUT_W are impossible because OUT_W ≥ IN_W+2.
- Latency: 1 cycle. Data accepted at edge N is visible on out_data with out_valid=1 after edge N.
- out_data and out_mode hold stable while out_valid && !out_ready. No change until the output transfer.
- In-order, lossless. Every accepted input produces exactly one output transfer. No duplicates.
- Main register state:
  - EMPTY: out_valid=0. An accept moves to FULL.
  - FULL: out_valid=1.
    - Output transfer with no accept → EMPTY.
    - Output transfer with a simultaneous accept → stays FULL with the new data. Full throughput, 1 result/cycle.
    - No output transfer → behaviour depends on IMM_EXT_SKID_EN (see Optional Feature).
- in_valid deasserted: in_imm and in_mode are don't-care and never captured.
- Reset, including mid-operation:
  - Forces out_valid=0, out_data=0, out_mode=2'b00, and the skid entry empty.
  - in_ready=1 in the cycle after reset.
  - In-flight data is discarded. An input presented in the same cycle as reset is not accepted.
- out_data is 0 whenever out_valid=0 after reset. It is not cleared after a drain; stale data may remain.

Optional Feature:
- Macro: IMM_EXT_SKID_EN.
- Defined:
  - A 1-entry skid register sits behind the main output register.
  - in_ready is a registered signal equal to !skid_full. There is no combinational path from out_ready to in_ready.
  - FULL with no output transfer and an accept: the new result goes to skid. in_ready drops to 0 on the next cycle.
  - On the next output transfer, skid moves to the main register and skid clears. in_ready returns to 1 on the cycle after.
  - Skid full and main output transfer with a simultaneous accept cannot occur, because in_ready=0.
- Undefined:
  - No skid register.
  - in_ready = !out_valid || out_ready, combinational.
  - FULL with no output transfer forces in_ready=0.

Test Plan:
- Sign/zero extension: in_mode=00, in_imm=16'hFFF8 → out_data=32'hFFFFFFF8 one cycle after accept. in_mode=01, same input → 32'h0000FFF8. in_imm=16'h8000 with modes 00 and 01 → 32'hFFFF8000 and 32'h00008000.
- Upper and branch modes:
  - in_mode=10, in_imm=16'h1234 → 32'h12340000.
  - in_mode=11, in_imm=16'hFFFF → 32'hFFFFFFFC.
  - in_mode=11, in_imm=16'h0007 → 32'h0000001C.
  - out_mode echoes the input mode in each case.
- Streaming: in_valid=1 for 8 consecutive cycles with values 1..8 (mode 00) and out_ready=1 throughout → 8 outputs on 8 consecutive cycles, in order, 1-cycle latency.
- Backpressure: stream 1..4 with out_ready=0 for cycles 2-5, then 1.
  - With IMM_EXT_SKID_EN: in_ready falls one cycle after the second accept.
  - Without it: in_ready falls combinationally.
  - Both builds: out_data holds 1 stable while stalled; outputs are 1,2,3,4 with none lost or duplicated.
- Reset mid-operation: assert reset for 1 cycle while out_valid=1, out_ready=0 and the skid is full → next cycle out_valid=0, out_data=0, out_mode=0, in_ready=1. The next accepted 16'h0005 (mode 00) emerges as 32'h00000005 alone.
- Parameter sweep: IN_W=12, OUT_W=32.
  - in_mode=00, 12'h800 → 32'hFFFFF800.
  - in_mode=10, 12'hABC → 32'hABC00000.
  - in_mode=11, 12'hFFF → 32'hFFFFFFFC.
